// File: rtl/debouncer_pkg.sv
// Shared definitions for the debouncer bank: channel FSM state encoding and default parameter values.
package debouncer_pkg;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    localparam int   DB_NUM_CH      = 8;
    localparam int   DB_CNT_W       = 16;
    localparam int   DB_HOLD        = 100;
    localparam int   DB_PRESCALE    = 1000;
    localparam int   DB_PRE_W       = 32;
    localparam int   DB_SYNC_STAGES = 2;
    localparam logic DB_RESET_VAL   = 1'b0;

endpackage

// File: rtl/debouncer_channel.sv
// One debounce channel: synchroniser, stable/pending FSM with tick-driven hold counter, edge pulses.
// Latency: SYNC_STAGES+HOLD+1 edges with a tick every cycle; otherwise HOLD-1..HOLD ticks after pending entry.
// Backpressure: none; outputs are registered levels and single-cycle pulses.
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int   CNT_W       = DB_CNT_W,
    parameter int   HOLD        = DB_HOLD,
    parameter int   SYNC_STAGES = DB_SYNC_STAGES,
    parameter logic RESET_VAL   = DB_RESET_VAL
) (
    input  logic clk,
    input  logic reset,
    input  logic in_switch,
    input  logic tick,
    output logic out_switch,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_d, rise_d, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_ff <= {SYNC_STAGES{RESET_VAL}};
        else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], in_switch};
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DB_STABLE;
            cnt_q      <= '0;
            out_switch <= RESET_VAL;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_switch <= out_d;
            rise       <= rise_d;
            fall       <= fall_d;
        end
    end

    // Any sample matching the current output while pending throws the whole count away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_switch;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (sync != out_switch) begin
                    state_d = DB_PENDING;
                    cnt_d   = CNT_W'(HOLD);
                end
            end
            DB_PENDING: begin
                if (sync == out_switch) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (tick && cnt_q == CNT_W'(1)) begin
                    out_d   = sync;
                    rise_d  = sync;
                    fall_d  = ~sync;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (tick && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/debouncer_bank.sv
// NUM_CH-channel debouncer with one shared tick prescaler; DEBOUNCER_IRQ_EN adds sticky change flags and irq.
// Latency: per channel SYNC_STAGES+HOLD+1 edges at PRESCALE=1, else HOLD-1..HOLD ticks after pending entry.
// Backpressure: none; change flags hold until written 1 via change_clr (a new edge beats a clear).
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int   NUM_CH      = DB_NUM_CH,
    parameter int   CNT_W       = DB_CNT_W,
    parameter int   HOLD        = DB_HOLD,
    parameter int   PRESCALE    = DB_PRESCALE,
    parameter int   PRE_W       = DB_PRE_W,
    parameter int   SYNC_STAGES = DB_SYNC_STAGES,
    parameter logic RESET_VAL   = DB_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] in_switch,
    output logic [NUM_CH-1:0] out_switch,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
`ifdef DEBOUNCER_IRQ_EN
    ,
    input  logic [NUM_CH-1:0] change_clr,
    output logic [NUM_CH-1:0] change,
    output logic              irq
`endif
);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PRE_W'(1);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debouncer_channel #(
            .CNT_W      (CNT_W),
            .HOLD       (HOLD),
            .SYNC_STAGES(SYNC_STAGES),
            .RESET_VAL  (RESET_VAL)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in_switch (in_switch[i]),
            .tick      (tick),
            .out_switch(out_switch[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

`ifdef DEBOUNCER_IRQ_EN
    logic [NUM_CH-1:0] change_q;

    // Flags follow the registered pulses, so the flag lags rise/fall by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) change_q <= '0;
        else       change_q <= (change_q & ~change_clr) | rise | fall;
    end

    assign change = change_q;
    assign irq    = |change_q;
`endif

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: instance A (PRESCALE=1, HOLD=2**CNT_W-1) checked every cycle against a
// scoreboard model; instance B (PRESCALE=10, HOLD=3) checked for latency window and channel independence.
module tb_debouncer_bank;

    localparam int NCH    = 8;
    localparam int A_HOLD = 7;
    localparam int A_LAT  = 2 + A_HOLD + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NCH-1:0] a_in, a_out, a_rise, a_fall, a_clr;
    logic [NCH-1:0] b_in, b_out, b_rise, b_fall;
`ifdef DEBOUNCER_IRQ_EN
    logic [NCH-1:0] a_change, b_change, b_clr;
    logic           a_irq, b_irq;
`endif

    debouncer_bank #(
        .NUM_CH(NCH), .CNT_W(3), .HOLD(A_HOLD), .PRESCALE(1), .PRE_W(4),
        .SYNC_STAGES(2), .RESET_VAL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .in_switch(a_in), .out_switch(a_out),
        .rise(a_rise), .fall(a_fall)
`ifdef DEBOUNCER_IRQ_EN
        , .change_clr(a_clr), .change(a_change), .irq(a_irq)
`endif
    );

    debouncer_bank #(
        .NUM_CH(NCH), .CNT_W(4), .HOLD(3), .PRESCALE(10), .PRE_W(4),
        .SYNC_STAGES(2), .RESET_VAL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .in_switch(b_in), .out_switch(b_out),
        .rise(b_rise), .fall(b_fall)
`ifdef DEBOUNCER_IRQ_EN
        , .change_clr(b_clr), .change(b_change), .irq(b_irq)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: output follows once the synchronised input has disagreed with it
    // on HOLD+1 consecutive clock edges.
    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] change;
        logic           irq;
    } exp_t;

    exp_t           sb_q[$];
    logic [NCH-1:0] m_s0, m_s1, m_out, m_rise, m_fall, m_chg;
    int             m_mis[NCH];
    logic [NCH-1:0] cur;

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = '0;
        for (int i = 0; i < NCH; i++) m_mis[i] = 0;
        sb_q.delete();
    endtask

    task automatic model_clk(input logic [NCH-1:0] din, input logic [NCH-1:0] clr);
        exp_t e;
        m_chg  = (m_chg & ~clr) | m_rise | m_fall;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_s1[i] != m_out[i]) begin
                m_mis[i]++;
                if (m_mis[i] == A_HOLD + 1) begin
                    m_out[i] = m_s1[i];
                    if (m_s1[i]) m_rise[i] = 1'b1;
                    else         m_fall[i] = 1'b1;
                    m_mis[i] = 0;
                end
            end else begin
                m_mis[i] = 0;
            end
        end
        m_s1 = m_s0;
        m_s0 = din;
        e.out = m_out; e.rise = m_rise; e.fall = m_fall; e.change = m_chg; e.irq = |m_chg;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [NCH-1:0] din, input logic [NCH-1:0] clr);
        exp_t e;
        a_in  = din;
        a_clr = clr;
        @(posedge clk);
        model_clk(din, clr);
        @(negedge clk);
        e = sb_q.pop_front();
        check("a_out", 32'(a_out), 32'(e.out));
        check("a_rise", 32'(a_rise), 32'(e.rise));
        check("a_fall", 32'(a_fall), 32'(e.fall));
`ifdef DEBOUNCER_IRQ_EN
        check("a_change", 32'(a_change), 32'(e.change));
        check("a_irq", 32'(a_irq), 32'(e.irq));
`endif
    endtask

    task automatic wait_out(input int ch, input logic val, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step(cur, '0);
            if (a_out[ch] === val) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat, lat1, lat5;

    initial begin
        reset = 1'b1;
        a_in = '0; a_clr = '0; b_in = '0; cur = '0;
`ifdef DEBOUNCER_IRQ_EN
        b_clr = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_a_out", 32'(a_out), 32'h0);
        check("rst_a_pulse", 32'(a_rise | a_fall), 32'h0);
        check("rst_b_out", 32'(b_out), 32'h0);
`ifdef DEBOUNCER_IRQ_EN
        check("rst_irq", 32'(a_irq), 32'h0);
`endif
        reset = 1'b0;
        repeat (5) step(cur, '0);

        // B: two channels toggled together must update together, within the tick window.
        for (int phase = 0; phase < 2; phase++) begin
            b_in = (phase == 0) ? 8'h22 : 8'h00;
            lat1 = -1; lat5 = -1;
            for (int n = 1; n <= 60; n++) begin
                step(cur, '0);
                if (lat1 < 0 && b_out[1] == b_in[1]) begin
                    lat1 = n;
                    check("b_edge_pulse", 32'(phase == 0 ? b_rise : b_fall), 32'h22);
                end
                if (lat5 < 0 && b_out[5] == b_in[5]) lat5 = n;
                check("b_other_ch", 32'(b_out & 8'hdd), 32'h0);
            end
            check("b_lat_window", 32'(lat1 >= 24 && lat1 <= 33), 32'h1);
            check("b_lat_same", 32'(lat5), 32'(lat1));
        end

        // Clean edge: exact latency with the hold count at its maximum.
        cur[0] = 1'b1;
        wait_out(0, 1'b1, lat);
        check("lat_clean_rise", 32'(lat), 32'(A_LAT));

        // Short glitch rejected, then the timer restarts from the final edge.
        cur[2] = 1'b1; repeat (3) step(cur, '0);
        cur[2] = 1'b0; repeat (2) step(cur, '0);
        check("glitch_out", 32'(a_out[2]), 32'h0);
        cur[2] = 1'b1;
        wait_out(2, 1'b1, lat);
        check("lat_after_glitch", 32'(lat), 32'(A_LAT));
        cur[0] = 1'b0; cur[2] = 1'b0;
        wait_out(0, 1'b0, lat);
        check("lat_clean_fall", 32'(lat), 32'(A_LAT));
        repeat (5) step(cur, '0);

        // Random bouncing on all channels at once.
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
            step(cur, '0);
        end

        // Reset in the middle of a pending count.
        cur = '0;
        repeat (20) step(cur, '0);
        cur[3] = 1'b1;
        repeat (5) step(cur, '0);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_out", 32'(a_out), 32'h0);
        check("midrst_pulse", 32'(a_rise | a_fall), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_out(3, 1'b1, lat);
        check("lat_after_reset", 32'(lat), 32'(A_LAT));

`ifdef DEBOUNCER_IRQ_EN
        repeat (2) step(cur, '1);
        check("irq_cleared", 32'(a_irq), 32'h0);
        cur[0] = 1'b1;
        wait_out(0, 1'b1, lat);
        step(cur, 8'h01);
        check("chg_set_wins", 32'(a_change[0]), 32'h1);
        check("irq_set", 32'(a_irq), 32'h1);
        step(cur, 8'h01);
        check("chg_clear", 32'(a_change[0]), 32'h0);
        check("irq_clear", 32'(a_irq), 32'h0);
        cur[0] = 1'b0;
        wait_out(0, 1'b0, lat);
        step(cur, '0);
        check("chg_on_fall", 32'(a_change[0]), 32'h1);
        step(cur, 8'h01);
        check("chg_clear2", 32'(a_change[0]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
